// File: rtl/vector_class_value_synthesizer.sv
// vector_class_value_synthesizer
//   Reverse of the FP classify path. It turns fclass-style 10-bit one-hot class
//   masks into one canonical IEEE-754 value of that class per lane.
//   Double-precision mode has one lane. Single-precision mode has two lanes.
//   The path is a 2-stage valid/ready pipeline with full throughput.
//
// Ports
//   clock            : rising-edge clock
//   reset_n          : synchronous active-low reset
//   execution_vector : only .bit_mode is used
//   vs2              : class masks (64b: [9:0]; 32b: lane0 [9:0], lane1 [41:32])
//   in_valid/in_ready: input handshake
//   vd               : synthesized value(s) (64b: [63:0]; 32b: lane0 [31:0], lane1 [63:32])
//   out_valid/out_ready : output handshake
//   invalid_mask     : per-lane flag for a rejected mask (64b mode uses only [0])
//   err_count        : saturating count of invalid lanes retired; present only
//                      when VECTOR_CLASS_SYNTH_ERR_COUNT_EN is defined
//
// Parameters
//   STRICT_ONEHOT    : 1 rejects zero and multi-bit masks; 0 lets the lowest set bit win
//   ERR_COUNT_WIDTH  : width of err_count

package vector_class_value_synthesizer_pkg;
  typedef enum logic [1:0] {
    DISABLED_BIT_MODE  = 2'd0,
    ENABLED_32BIT_MODE = 2'd1,
    ENABLED_64BIT_MODE = 2'd2,
    RESERVED_BIT_MODE  = 2'd3
  } bit_mode_t;

  typedef struct packed {
    bit_mode_t bit_mode;
  } execution_vector_t;
endpackage

module vector_class_value_synthesizer
  import vector_class_value_synthesizer_pkg::*;
#(
  parameter int unsigned STRICT_ONEHOT   = 1,
  parameter int unsigned ERR_COUNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  execution_vector_t          execution_vector,
  input  logic [63:0]                vs2,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [63:0]                vd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 invalid_mask
`ifdef VECTOR_CLASS_SYNTH_ERR_COUNT_EN
  ,
  output logic [ERR_COUNT_WIDTH-1:0] err_count
`endif
);

  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;

  if (ERR_COUNT_WIDTH < 1) begin : g_bad_width
    $error("ERR_COUNT_WIDTH must be at least 1");
  end

  function automatic logic mask_valid(input logic [9:0] m);
    if (STRICT_ONEHOT != 0) return $onehot(m);
    else                    return |m;
  endfunction

  // Scan from the top down, so the lowest set bit is the one that remains.
  function automatic logic [3:0] class_idx(input logic [9:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 10; i > 0; i--) begin
      if (m[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

  function automatic logic [63:0] value64(input logic [3:0] idx);
    case (idx)
      4'd0:    return 64'hFFF0_0000_0000_0000;
      4'd1:    return 64'hBFF0_0000_0000_0000;
      4'd2:    return 64'h8000_0000_0000_0001;
      4'd3:    return 64'h8000_0000_0000_0000;
      4'd4:    return 64'h0000_0000_0000_0000;
      4'd5:    return 64'h0000_0000_0000_0001;
      4'd6:    return 64'h3FF0_0000_0000_0000;
      4'd7:    return 64'h7FF0_0000_0000_0000;
      4'd8:    return 64'h7FF0_0000_0000_0001;
      default: return QNAN64;
    endcase
  endfunction

  function automatic logic [31:0] value32(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'hFF80_0000;
      4'd1:    return 32'hBF80_0000;
      4'd2:    return 32'h8000_0001;
      4'd3:    return 32'h8000_0000;
      4'd4:    return 32'h0000_0000;
      4'd5:    return 32'h0000_0001;
      4'd6:    return 32'h3F80_0000;
      4'd7:    return 32'h7F80_0000;
      4'd8:    return 32'h7F80_0001;
      default: return QNAN32;
    endcase
  endfunction

  logic [9:0]  mask0;
  logic [9:0]  mask1;
  logic [63:0] d_vd;
  logic [1:0]  d_inv;

  logic        s1_valid;
  logic [63:0] s1_vd;
  logic [1:0]  s1_inv;
  logic        s2_valid;
  logic        s1_en;
  logic        s2_en;

  logic unused_vs2;
  assign unused_vs2 = ^{vs2[31:10], vs2[63:42]};

  assign mask0 = vs2[9:0];
  assign mask1 = vs2[41:32];

  always_comb begin
    d_vd  = '0;
    d_inv = '0;
    case (execution_vector.bit_mode)
      ENABLED_64BIT_MODE: begin
        d_inv[0] = !mask_valid(mask0);
        d_vd     = d_inv[0] ? QNAN64 : value64(class_idx(mask0));
      end
      ENABLED_32BIT_MODE: begin
        d_inv[0]    = !mask_valid(mask0);
        d_inv[1]    = !mask_valid(mask1);
        d_vd[31:0]  = d_inv[0] ? QNAN32 : value32(class_idx(mask0));
        d_vd[63:32] = d_inv[1] ? QNAN32 : value32(class_idx(mask1));
      end
      default: ;
    endcase
  end

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid     <= 1'b0;
      s1_vd        <= '0;
      s1_inv       <= '0;
      s2_valid     <= 1'b0;
      vd           <= '0;
      invalid_mask <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        s1_vd    <= d_vd;
        s1_inv   <= d_inv;
      end
      // When S1 is empty, loading it also clears s2_valid on the retiring beat.
      if (s2_en) begin
        s2_valid     <= s1_valid;
        vd           <= s1_vd;
        invalid_mask <= s1_inv;
      end
    end
  end

`ifdef VECTOR_CLASS_SYNTH_ERR_COUNT_EN
  // The extra top bit detects overflow. A carry out means the counter saturates.
  logic [ERR_COUNT_WIDTH:0] err_sum;
  assign err_sum = {1'b0, err_count}
                 + (ERR_COUNT_WIDTH+1)'({1'b0, invalid_mask[0]} + {1'b0, invalid_mask[1]});

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (s2_valid && out_ready) begin
      err_count <= err_sum[ERR_COUNT_WIDTH] ? '1 : err_sum[ERR_COUNT_WIDTH-1:0];
    end
  end
`endif

endmodule
